// File: rtl/de_regfile_sb.sv
// de_regfile_sb: decode-stage register file with write-first bypass,
// a pending-load scoreboard that drives the hazard stall, and a
// req/ack debug read port that stalls the pipeline while it runs.
//
// Optional feature: define DE_RF_ZERO_REG_EN to make index 0 a hard-wired
// zero register. Writes to it are dropped, it never bypasses a value, and it
// is never marked pending.
//
// Debug handshake: dbg_req is a level. The FSM accepts it in IDLE and raises
// dbg_stall. One cycle later it reads the register and raises dbg_ack.
// dbg_ack, dbg_data and dbg_stall then hold until dbg_req is observed low.
// A new request needs dbg_req to be low for at least one cycle.
// fsm_state exposes the debug FSM state for observation.
module de_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    input  logic [NRD-1:0]        rd_use,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic                  hz_stall,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  sb_flush,
    input  logic                  dbg_req,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic                  dbg_ack,
    output logic [DATA_W-1:0]     dbg_data,
    output logic                  dbg_stall,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_ACK  = 2'd2
    } dbg_state_t;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic [ADDR_W-1:0] rd_idx [NRD];
    logic [ADDR_W-1:0] cap_addr;
    dbg_state_t        state;
    dbg_state_t        state_nxt;
    logic              wr_ok;
    logic              iss_ok;

`ifdef DE_RF_ZERO_REG_EN
    assign wr_ok  = wr_en && (wr_addr != '0);
    assign iss_ok = iss_en && (iss_addr != '0);
`else
    assign wr_ok  = wr_en;
    assign iss_ok = iss_en;
`endif

    // Slice the packed read-address bus into one index per port.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_idx[i] = rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Architectural register array; write-back is never blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Registered read ports with a write-first bypass of a same-cycle write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (wr_ok && (wr_addr == rd_idx[i])) begin
                    rd_data[i*DATA_W +: DATA_W] <= wr_data;
                end else begin
                    rd_data[i*DATA_W +: DATA_W] <= regs[rd_idx[i]];
                end
            end
        end
    end

    // Scoreboard next state: flush beats issue, and issue beats a same-index clear.
    always_comb begin
        pend_nxt = pend;
        if (sb_flush) begin
            pend_nxt = '0;
        end else begin
            if (wr_en) begin
                pend_nxt[wr_addr] = 1'b0;
            end
            if (iss_ok) begin
                pend_nxt[iss_addr] = 1'b1;
            end
        end
    end

    // Scoreboard pending vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Busy flags come from registered pending state only.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = pend[rd_idx[i]];
        end
    end

    assign hz_stall = (|(rd_busy & rd_use)) | dbg_stall;

    // Debug FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dbg_req) state_nxt = S_READ;
            S_READ:  state_nxt = S_ACK;
            S_ACK:   if (!dbg_req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Debug FSM state register, address capture and read-out data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cap_addr <= '0;
            dbg_data <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && dbg_req) begin
                cap_addr <= dbg_addr;
            end
            if (state == S_READ) begin
                if (wr_ok && (wr_addr == cap_addr)) begin
                    dbg_data <= wr_data;
                end else begin
                    dbg_data <= regs[cap_addr];
                end
            end
        end
    end

    assign dbg_ack   = (state == S_ACK);
    assign dbg_stall = (state != S_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_de_regfile_sb.sv
// Directed bench for de_regfile_sb (default parameters: 32x32, two read ports).
module tb_de_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD-1:0]        rd_use;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  hz_stall;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  iss_en;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  sb_flush;
    logic                  dbg_req;
    logic [ADDR_W-1:0]     dbg_addr;
    logic                  dbg_ack;
    logic [DATA_W-1:0]     dbg_data;
    logic                  dbg_stall;
    logic [1:0]            fsm_state;

    int checks = 0;
    int errors = 0;

    de_regfile_sb #(
        .DATA_W(DATA_W), .NREG(32), .ADDR_W(ADDR_W), .NRD(NRD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
        .rd_busy(rd_busy), .hz_stall(hz_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .sb_flush(sb_flush),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
        .dbg_data(dbg_data), .dbg_stall(dbg_stall), .fsm_state(fsm_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        iss_en = 1'b1; iss_addr = a;
        tick();
        iss_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rd_addr = '0; rd_use = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; iss_en = 1'b0; iss_addr = '0; sb_flush = 1'b0;
        dbg_req = 1'b0; dbg_addr = '0;
        repeat (3) tick();
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_dbg_ack", dbg_ack, 0);
        chk("rst_dbg_stall", dbg_stall, 0);
        chk("rst_hz_stall", hz_stall, 0);
        rst_n = 1'b1;
        tick();

        // Unwritten registers read as zero.
        set_rd(5'd5, 5'd9);
        tick();
        chk("read_unwritten", rd_data, 64'h0);

        // Write then read one cycle later.
        set_rd(5'd1, 5'd1);
        write(5'd5, 32'hDEADBEEF);
        set_rd(5'd5, 5'd1);
        tick();
        chk("read_after_write", rd_data[31:0], 64'hDEADBEEF);

        // Write-first bypass, duplicate address on both ports.
        set_rd(5'd7, 5'd7);
        write(5'd7, 32'h12345678);
        chk("bypass_p1", rd_data[63:32], 64'h12345678);
        chk("bypass_p0_dup", rd_data[31:0], 64'h12345678);

        // Scoreboard set / use / clear.
        set_rd(5'd3, 5'd5);
        rd_use = 2'b01;
        #1;
        chk("busy_before_issue", rd_busy[0], 0);
        issue(5'd3);
        chk("busy_after_issue", rd_busy[0], 1);
        chk("hz_after_issue", hz_stall, 1);
        rd_use = 2'b00;
        #1;
        chk("hz_not_used", hz_stall, 0);
        rd_use = 2'b01;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        chk("busy_during_clear", rd_busy[0], 1);
        tick();
        wr_en = 1'b0;
        chk("busy_after_clear", rd_busy[0], 0);
        chk("hz_after_clear", hz_stall, 0);

        // Same-cycle issue and write-back on the same index: issue wins.
        iss_en = 1'b1; iss_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h44;
        tick();
        iss_en = 1'b0; wr_en = 1'b0;
        chk("issue_beats_clear", rd_busy[0], 1);

        // Flush beats a same-cycle issue.
        issue(5'd2);
        issue(5'd9);
        issue(5'd30);
        set_rd(5'd2, 5'd9);
        #1;
        chk("busy_2_9_set", rd_busy, 2'b11);
        sb_flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        sb_flush = 1'b0; iss_en = 1'b0;
        chk("flush_2_9", rd_busy, 2'b00);
        set_rd(5'd30, 5'd4);
        #1;
        chk("flush_30_4", rd_busy, 2'b00);
        set_rd(5'd3, 5'd3);
        #1;
        chk("flush_3", rd_busy, 2'b00);
        rd_use = 2'b00;

        // Debug read of reg2.
        write(5'd2, 32'h2);
        dbg_req = 1'b1; dbg_addr = 5'd2;
        tick();
        chk("dbg_stall_c1", dbg_stall, 1);
        chk("dbg_ack_c1", dbg_ack, 0);
        chk("dbg_hz_c1", hz_stall, 1);
        dbg_addr = 5'd5;
        tick();
        chk("dbg_ack_c2", dbg_ack, 1);
        chk("dbg_data_c2", dbg_data, 64'h2);
        tick();
        chk("dbg_ack_hold", dbg_ack, 1);
        chk("dbg_data_hold", dbg_data, 64'h2);
        chk("dbg_stall_hold", dbg_stall, 1);
        dbg_req = 1'b0;
        tick();
        chk("dbg_ack_clr", dbg_ack, 0);
        chk("dbg_stall_clr", dbg_stall, 0);

        // Debug read with a write-back to the same index during READ.
        dbg_req = 1'b1; dbg_addr = 5'd6;
        tick();
        write(5'd6, 32'h0000ABCD);
        chk("dbg_bypass", dbg_data, 64'hABCD);
        dbg_req = 1'b0;
        tick();

        // Reset while in READ aborts the transaction.
        dbg_req = 1'b1; dbg_addr = 5'd2;
        tick();
        chk("dbg_in_read", fsm_state, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_stall", dbg_stall, 0);
        chk("abort_rd_data", rd_data, 64'h0);
        tick();
        tick();
        chk("abort_no_ack", dbg_ack, 0);
        dbg_req = 1'b0;
        rst_n = 1'b1;
        set_rd(5'd5, 5'd2);
        tick();
        chk("regs_cleared", rd_data, 64'h0);

        // Index 0 behaviour.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        set_rd(5'd0, 5'd0);
        #1;
`ifdef DE_RF_ZERO_REG_EN
        chk("zero_busy", rd_busy, 2'b00);
        tick();
        chk("zero_read", rd_data[31:0], 64'h0);
`else
        chk("zero_busy", rd_busy, 2'b11);
        tick();
        chk("zero_read", rd_data[31:0], 64'hFFFF);
`endif
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hAAAA;
        tick();
        wr_en = 1'b0;
`ifdef DE_RF_ZERO_REG_EN
        chk("zero_bypass", rd_data[63:32], 64'h0);
`else
        chk("zero_bypass", rd_data[63:32], 64'hAAAA);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
